// File: rtl/alu_op_sequencer_pkg.sv
// Shared widths, ALU function codes, status bit indices and 6502 op encodings
// for the execute-stage sequencer, plus helpers mapping an op onto ALU inputs.
`ifndef ALU_OP_SEQUENCER_DEFS
`define ALU_OP_SEQUENCER_DEFS
`define REG_WIDTH 8
`define OPP_WIDTH 4
`define SUM 4'd0
`define AND 4'd1
`define OR  4'd2
`define XOR 4'd3
`define SR  4'd4
`define NOP 4'd15
`define CARRY      0
`define ZERO       1
`define INT_DIS    2
`define DEC        3
`define BREAK      4
`define V_OVERFLOW 6
`define NEG        7
`define OP_ADC 4'd0
`define OP_SBC 4'd1
`define OP_AND 4'd2
`define OP_ORA 4'd3
`define OP_EOR 4'd4
`define OP_CMP 4'd5
`define OP_ASL 4'd6
`define OP_LSR 4'd7
`define OP_ROL 4'd8
`define OP_ROR 4'd9
`define OP_INC 4'd10
`define OP_DEC 4'd11
`endif

package alu_op_sequencer_pkg;

    typedef logic [`REG_WIDTH-1:0] reg_t;

    typedef struct packed {
        logic [`OPP_WIDTH-1:0] func;
        reg_t                  a;
        reg_t                  b;
        logic                  carry;
    } alu_req_t;

    function automatic logic is_legal(input logic [3:0] op);
        return op <= `OP_DEC;
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return (op == `OP_LSR) || (op == `OP_ROR);
    endfunction

    // Subtraction and compare reuse the adder with an inverted second operand.
    function automatic alu_req_t alu_map(input logic [3:0] op, input reg_t a,
                                         input reg_t b, input logic c);
        alu_req_t r;
        r.func  = `SUM;
        r.a     = a;
        r.b     = b;
        r.carry = c;
        case (op)
            `OP_SBC: r.b = ~b;
            `OP_CMP: begin r.b = ~b; r.carry = 1'b1; end
            `OP_AND: r.func = `AND;
            `OP_ORA: r.func = `OR;
            `OP_EOR: r.func = `XOR;
            `OP_ASL: begin r.b = a; r.carry = 1'b0; end
            `OP_ROL: r.b = a;
            `OP_INC: begin r.b = '0; r.carry = 1'b1; end
            `OP_DEC: begin r.b = '1; r.carry = 1'b0; end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_p_flag_merge.sv
// Combinational next-P computation: folds an op's result and carry into the
// processor status register.
module p_flag_merge
    import alu_op_sequencer_pkg::*;
(
    input  logic [3:0] op,
    input  reg_t       a,
    input  reg_t       b,
    input  reg_t       result,
    input  logic       alu_carry,
    input  reg_t       p_in,
    output reg_t       p_next
);

    logic unused_bits;
    assign unused_bits = ^{a[`REG_WIDTH-2:1], b[`REG_WIDTH-2:0]};

    // NOTE: p_next takes p_in first so every path assigns it and no latch is inferred.
    always_comb begin
        p_next              = p_in;
        p_next[`NEG]        = result[`REG_WIDTH-1];
        p_next[`ZERO]       = (result == '0);
        case (op)
            `OP_ADC, `OP_SBC: begin
                p_next[`CARRY]      = alu_carry;
                p_next[`V_OVERFLOW] = (a[`REG_WIDTH-1] == b[`REG_WIDTH-1]) &&
                                      (result[`REG_WIDTH-1] != a[`REG_WIDTH-1]);
            end
            `OP_CMP, `OP_ASL, `OP_ROL: p_next[`CARRY] = alu_carry;
            `OP_LSR, `OP_ROR:          p_next[`CARRY] = a[0];
            default: ;
        endcase
        p_next[5] = 1'b1;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Execute-stage controller: one 6502 op request becomes one ALU handshake
// (or a local shift), and the returned flags are merged into P.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int   TIMEOUT_CYCLES = 4,
    parameter reg_t P_RESET        = 8'h20
) (
    input  logic                  phi1,
    input  logic                  reset_n,
    input  logic                  req_valid,
    input  logic [3:0]            req_op,
    input  logic [`REG_WIDTH-1:0] req_a,
    input  logic [`REG_WIDTH-1:0] req_b,
    output logic                  req_ready,
    input  logic                  p_load,
    input  logic [`REG_WIDTH-1:0] p_wdata,
    output logic [`REG_WIDTH-1:0] alu_a,
    output logic [`REG_WIDTH-1:0] alu_b,
    output logic [`OPP_WIDTH-1:0] alu_func,
    output logic [`REG_WIDTH-1:0] alu_status,
    output logic                  alu_dec,
    input  logic [`REG_WIDTH-1:0] alu_dout,
    input  logic [`REG_WIDTH-1:0] alu_status_out,
    input  logic                  alu_wout,
    output logic                  done,
    output logic [`REG_WIDTH-1:0] result,
    output logic                  write_result,
    output logic [`REG_WIDTH-1:0] p_reg,
    output logic                  timeout_err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GAP   = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_WB    = 3'd4;

    localparam int              CW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state;
    logic [3:0]            op_q;
    logic [`OPP_WIDTH-1:0] func_q;
    logic [CW-1:0]         cnt;

    logic       in_idle;
    logic [3:0] m_op;
    reg_t       m_a, m_b, m_res, shift_res, p_next;
    alu_req_t   req_map;
    logic       unused_status;

    assign alu_dec       = 1'b0;
    assign in_idle       = (state == ST_IDLE);
    assign req_ready     = in_idle && !p_load;
    assign unused_status = ^alu_status_out[`REG_WIDTH-1:1];

    assign req_map   = alu_map(req_op, req_a, req_b, p_reg[`CARRY]);
    assign shift_res = {(req_op == `OP_ROR) & p_reg[`CARRY], req_a[`REG_WIDTH-1:1]};

    // Local shifts merge from the request in IDLE; ALU ops merge from the held ALU inputs.
    assign m_op  = in_idle ? req_op    : op_q;
    assign m_a   = in_idle ? req_a     : alu_a;
    assign m_b   = in_idle ? req_b     : alu_b;
    assign m_res = in_idle ? shift_res : alu_dout;

    p_flag_merge u_merge (
        .op        (m_op),
        .a         (m_a),
        .b         (m_b),
        .result    (m_res),
        .alu_carry (alu_status_out[`CARRY]),
        .p_in      (p_reg),
        .p_next    (p_next)
    );

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge phi1) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            op_q         <= '0;
            func_q       <= `NOP;
            cnt          <= '0;
            alu_func     <= `NOP;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_status   <= '0;
            p_reg        <= P_RESET;
            result       <= '0;
            write_result <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (p_load) begin
                        p_reg <= p_wdata | 8'h20;
                    end else if (req_valid) begin
                        if (!is_legal(req_op)) begin
                            timeout_err <= 1'b1;
                        end else if (is_shift(req_op)) begin
                            result       <= shift_res;
                            p_reg        <= p_next;
                            write_result <= 1'b1;
                            done         <= 1'b1;
                            state        <= ST_WB;
                        end else begin
                            op_q               <= req_op;
                            func_q             <= req_map.func;
                            alu_a              <= req_map.a;
                            alu_b              <= req_map.b;
                            alu_status         <= '0;
                            alu_status[`CARRY] <= req_map.carry;
                            alu_func           <= `NOP;
                            state              <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    alu_func <= func_q;
                    state    <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_wout) begin
                        if (op_q != `OP_CMP) result <= alu_dout;
                        write_result <= (op_q != `OP_CMP);
                        p_reg        <= p_next;
                        done         <= 1'b1;
                        alu_func     <= `NOP;
                        state        <= ST_WB;
                    end else if (cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        alu_func    <= `NOP;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WB:   state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU responder, a hand-computed
// vector table, directed corner sequences and randomized ops against a model.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    logic       phi1 = 1'b0, reset_n = 1'b0;
    logic       req_valid = 1'b0, p_load = 1'b0;
    logic [3:0] req_op = '0;
    logic [7:0] req_a = '0, req_b = '0, p_wdata = '0;
    logic       req_ready, alu_dec, done, write_result, timeout_err;
    logic [7:0] alu_a, alu_b, alu_status, result, p_reg;
    logic [3:0] alu_func;
    logic [7:0] alu_dout = '0, alu_status_out = '0;
    logic       alu_wout = 1'b0, armed = 1'b1, suppress = 1'b0;

    int n_vec = 0, n_bad = 0;

    alu_op_sequencer dut (
        .phi1(phi1), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .p_load(p_load),
        .p_wdata(p_wdata), .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_status(alu_status), .alu_dec(alu_dec), .alu_dout(alu_dout),
        .alu_status_out(alu_status_out), .alu_wout(alu_wout), .done(done),
        .result(result), .write_result(write_result), .p_reg(p_reg),
        .timeout_err(timeout_err)
    );

    always #5 phi1 = ~phi1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [8:0] alu_calc(input logic [3:0] f, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
        case (f)
            `SUM:    return {1'b0, a} + {1'b0, b} + {8'd0, cin};
            `AND:    return {1'b0, a & b};
            `OR:     return {1'b0, a | b};
            `XOR:    return {1'b0, a ^ b};
            default: return 9'd0;
        endcase
    endfunction

    // ALU responder: answers once per arming, re-arms when it sees the no-op code.
    always @(posedge phi1) begin
        if (alu_func == `NOP) begin
            armed    <= 1'b1;
            alu_wout <= 1'b0;
        end else if (armed && !suppress) begin
            alu_dout       <= alu_calc(alu_func, alu_a, alu_b, alu_status[0]) & 9'hFF;
            alu_status_out <= {7'b1010010, alu_calc(alu_func, alu_a, alu_b, alu_status[0]) >> 8};
            alu_wout       <= 1'b1;
            armed          <= 1'b0;
        end else begin
            alu_wout <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Spec-level model: plain integer arithmetic on the 6502 semantics.
    task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] p, output logic [7:0] val, output logic [7:0] pn,
                         output logic wr);
        int ua = a, ub = b, c = p[0];
        int sa = $signed(a), sb = $signed(b);
        int t = 0, st = 0;
        logic upd_c = 0, upd_v = 0, nc = 0;
        wr = 1'b1;
        case (op)
            `OP_ADC: begin t = ua + ub + c; st = sa + sb + c; nc = t > 255; upd_c = 1; upd_v = 1; end
            `OP_SBC: begin t = ua - ub - (1 - c); st = sa - sb - (1 - c); nc = t >= 0; upd_c = 1; upd_v = 1; end
            `OP_CMP: begin t = ua - ub; nc = t >= 0; upd_c = 1; wr = 1'b0; end
            `OP_AND: t = ua & ub;
            `OP_ORA: t = ua | ub;
            `OP_EOR: t = ua ^ ub;
            `OP_ASL: begin t = ua * 2; nc = t > 255; upd_c = 1; end
            `OP_ROL: begin t = ua * 2 + c; nc = t > 255; upd_c = 1; end
            `OP_LSR: begin t = ua / 2; nc = ua % 2; upd_c = 1; end
            `OP_ROR: begin t = ua / 2 + c * 128; nc = ua % 2; upd_c = 1; end
            `OP_INC: t = ua + 1;
            `OP_DEC: t = ua - 1;
            default: ;
        endcase
        val = t[7:0];
        pn  = p;
        pn[7] = val[7];
        pn[1] = (val == 8'd0);
        if (upd_c) pn[0] = nc;
        if (upd_v) pn[6] = (st > 127) || (st < -128);
        pn[5] = 1'b1;
    endtask

    task automatic set_p(input logic [7:0] v);
        @(negedge phi1);
        for (int w = 0; w < 8 && !req_ready; w++) @(negedge phi1);
        p_load  = 1'b1;
        p_wdata = v;
        @(posedge phi1); #1;
        p_load = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic got_done, output logic got_to,
                          output logic [3:0] f0, output logic [3:0] f1, output logic saw_func);
        @(negedge phi1);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        for (int w = 0; w < 8 && !req_ready; w++) @(negedge phi1);
        check("req_ready_before_accept", req_ready, 1);
        @(posedge phi1); #1;
        req_valid = 1'b0;
        lat = -1; got_done = 0; got_to = 0; saw_func = 0; f0 = 'x; f1 = 'x;
        for (int k = 0; k < 12; k++) begin
            if (k == 0) f0 = alu_func;
            if (k == 1) f1 = alu_func;
            if (alu_func !== `NOP) saw_func = 1;
            if (done === 1'b1) begin got_done = 1; lat = k; break; end
            if (timeout_err === 1'b1) begin got_to = 1; lat = k; break; end
            @(posedge phi1); #1;
        end
    endtask

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a, b, p_init, res, p;
        logic       wr;
        logic [3:0] lat;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int lat;
        logic got_done, got_to, saw, wr;
        logic [3:0] f0, f1;
        logic [7:0] exp_res, exp_p, val, last_res, pr;

        tbl[0]  = '{`OP_ADC, 8'h50, 8'h50, 8'h20, 8'hA0, 8'hE0, 1'b1, 4'd3};
        tbl[1]  = '{`OP_SBC, 8'h00, 8'h01, 8'h21, 8'hFF, 8'hA0, 1'b1, 4'd3};
        tbl[2]  = '{`OP_CMP, 8'h40, 8'h40, 8'h20, 8'hFF, 8'h23, 1'b0, 4'd3};
        tbl[3]  = '{`OP_ROR, 8'h01, 8'h00, 8'h21, 8'h80, 8'hA1, 1'b1, 4'd0};
        tbl[4]  = '{`OP_INC, 8'hFF, 8'h00, 8'h21, 8'h00, 8'h23, 1'b1, 4'd3};
        tbl[5]  = '{`OP_AND, 8'hF0, 8'h3C, 8'hC1, 8'h30, 8'h61, 1'b1, 4'd3};
        tbl[6]  = '{`OP_LSR, 8'h81, 8'h00, 8'h20, 8'h40, 8'h21, 1'b1, 4'd0};
        tbl[7]  = '{`OP_DEC, 8'h00, 8'h00, 8'h20, 8'hFF, 8'hA0, 1'b1, 4'd3};
        tbl[8]  = '{`OP_ASL, 8'h80, 8'h00, 8'h20, 8'h00, 8'h23, 1'b1, 4'd3};
        tbl[9]  = '{`OP_EOR, 8'hFF, 8'h0F, 8'h2C, 8'hF0, 8'hAC, 1'b1, 4'd3};
        tbl[10] = '{`OP_ROL, 8'h40, 8'h00, 8'h21, 8'h81, 8'hA0, 1'b1, 4'd3};
        tbl[11] = '{`OP_ORA, 8'h00, 8'h00, 8'hA0, 8'h00, 8'h22, 1'b1, 4'd3};
        tbl[12] = '{`OP_ADC, 8'hFF, 8'h01, 8'h20, 8'h00, 8'h23, 1'b1, 4'd3};
        tbl[13] = '{`OP_CMP, 8'h10, 8'h20, 8'h20, 8'h00, 8'hA0, 1'b0, 4'd3};

        // Reset state
        repeat (2) @(posedge phi1);
        #1;
        check("rst_p_reg", p_reg, 8'h20);
        check("rst_result", result, 8'h00);
        check("rst_done", done, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_alu_func", alu_func, `NOP);
        check("rst_alu_ab", {alu_a, alu_b}, 16'h0000);
        check("rst_req_ready", req_ready, 1);
        check("alu_dec", alu_dec, 0);
        @(negedge phi1);
        reset_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            set_p(tbl[i].p_init);
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, got_done, got_to, f0, f1, saw);
            check($sformatf("v%0d_done", i), got_done, 1);
            check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("v%0d_result", i), result, tbl[i].res);
            check($sformatf("v%0d_p_reg", i), p_reg, tbl[i].p);
            check($sformatf("v%0d_write_result", i), write_result, tbl[i].wr);
            if (tbl[i].lat == 4'd0) check($sformatf("v%0d_no_alu_func", i), saw, 0);
            else                    check($sformatf("v%0d_gap_nop", i), f0, `NOP);
            if (i == 1) check("sbc_alu_b_inverted", alu_b, 8'hFE);
        end
        @(posedge phi1); #1;
        check("done_single_cycle", done, 0);

        // Identical CMP back-to-back: GAP must drive NOP between the two ISSUEs
        set_p(8'h20);
        run_op(`OP_CMP, 8'h40, 8'h40, lat, got_done, got_to, f0, f1, saw);
        run_op(`OP_CMP, 8'h40, 8'h40, lat, got_done, got_to, f0, f1, saw);
        check("cmp2_gap_nop", f0, `NOP);
        check("cmp2_issue_sum", f1, `SUM);
        check("cmp2_done", got_done, 1);
        check("cmp2_p_reg", p_reg, 8'h23);

        // Illegal ops
        run_op(4'd12, 8'h12, 8'h34, lat, got_done, got_to, f0, f1, saw);
        check("illegal12_err", {got_to, got_done, 4'(lat)}, {1'b1, 1'b0, 4'd0});
        run_op(4'd15, 8'h12, 8'h34, lat, got_done, got_to, f0, f1, saw);
        check("illegal15_err", {got_to, got_done, 4'(lat)}, {1'b1, 1'b0, 4'd0});
        check("illegal_p_unchanged", p_reg, 8'h23);

        // p_load wins over req_valid in IDLE
        @(negedge phi1);
        req_valid = 1'b1; req_op = `OP_ADC; req_a = 8'h01; req_b = 8'h01;
        p_load = 1'b1; p_wdata = 8'h00;
        #1;
        check("pload_req_ready_low", req_ready, 0);
        @(posedge phi1); #1;
        p_load = 1'b0; req_valid = 1'b0;
        check("pload_p_reg", p_reg, 8'h20);
        saw = 0;
        for (int k = 0; k < 5; k++) begin
            if (done === 1'b1 || alu_func !== `NOP) saw = 1;
            @(posedge phi1); #1;
        end
        check("pload_req_not_accepted", saw, 0);

        // Randomized ops against the model
        last_res = 8'h00;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            logic [7:0] a, b;
            op = 4'($urandom_range(0, 11));
            a  = 8'($urandom);
            b  = 8'($urandom);
            pr = 8'($urandom) | 8'h20;
            set_p(pr);
            run_op(op, a, b, lat, got_done, got_to, f0, f1, saw);
            model(op, a, b, pr, val, exp_p, wr);
            exp_res = wr ? val : last_res;
            last_res = exp_res;
            check($sformatf("rnd%0d_op%0d_result", i, op), result, exp_res);
            check($sformatf("rnd%0d_op%0d_p_reg", i, op), p_reg, exp_p);
            check($sformatf("rnd%0d_op%0d_write_result", i, op), write_result, wr);
        end

        // Timeout: ALU never answers
        run_op(`OP_LSR, 8'h81, 8'h00, lat, got_done, got_to, f0, f1, saw);
        set_p(8'h2D);
        suppress = 1'b1;
        run_op(`OP_ADC, 8'h01, 8'h02, lat, got_done, got_to, f0, f1, saw);
        check("to_err_seen", got_to, 1);
        check("to_no_done", got_done, 0);
        check("to_latency", lat, 6);
        check("to_p_unchanged", p_reg, 8'h2D);
        check("to_result_unchanged", result, 8'h40);
        @(posedge phi1); #1;
        check("to_err_single_cycle", timeout_err, 0);
        check("to_back_in_idle", req_ready, 1);

        // Reset during WAIT of a second op
        @(negedge phi1);
        req_op = `OP_ADC; req_a = 8'h05; req_b = 8'h06; req_valid = 1'b1;
        @(posedge phi1); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge phi1);
        #1;
        check("wait_func_held", alu_func, `SUM);
        @(negedge phi1);
        reset_n = 1'b0;
        @(posedge phi1); #1;
        check("midop_rst_p_reg", p_reg, 8'h20);
        check("midop_rst_result", result, 8'h00);
        check("midop_rst_alu_func", alu_func, `NOP);
        check("midop_rst_idle", req_ready, 1);
        check("midop_rst_flags", {done, timeout_err}, 2'b00);
        suppress = 1'b0;
        @(negedge phi1);
        reset_n = 1'b1;

        // Normal operation resumes after reset
        run_op(`OP_ADC, 8'h50, 8'h50, lat, got_done, got_to, f0, f1, saw);
        check("post_rst_result", result, 8'hA0);
        check("post_rst_latency", lat, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
